// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one SlaveMemory port among NUM_M bus masters.
// All outputs are registered; each transfer runs IDLE -> BUSY -> DONE -> IDLE.
module mem_bus_arbiter #(
    parameter int NUM_M   = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int CW      = 9,
    parameter int TIMEOUT = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [NUM_M-1:0]    M_Req,
    input  logic [NUM_M*AW-1:0] M_Addr,
    input  logic [NUM_M*DW-1:0] M_DataIn,
    input  logic [NUM_M*CW-1:0] M_Control,
    output logic [NUM_M-1:0]    M_Gnt,
    output logic [NUM_M-1:0]    M_Done,
    output logic                M_Err,
    output logic [DW-1:0]       M_RData,
    output logic [AW-1:0]       S_Addr,
    output logic [DW-1:0]       S_DataIn,
    output logic [CW-1:0]       S_Control,
    output logic                S_En,
    input  logic [DW-1:0]       S_DataOut,
    input  logic                S_Ready
);

    localparam int PW   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int CNTW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_idx_q, gnt_idx_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [NUM_M-1:0] gnt_d, done_d;
    logic             err_d, s_en_d;
    logic [DW-1:0]    rdata_d, s_data_d;
    logic [AW-1:0]    s_addr_d;
    logic [CW-1:0]    s_ctl_d;

    logic          found;
    logic [PW-1:0] sel_idx;
    int            idx;

    // Scan requesters in circular order starting at the round-robin pointer.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        found   = 1'b0;
        sel_idx = '0;
        idx     = 0;
        for (int i = 0; i < NUM_M; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_M) idx = idx - NUM_M;
            if (!found && M_Req[idx]) begin
                found   = 1'b1;
                sel_idx = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        cnt_d     = cnt_q;
        gnt_d     = M_Gnt;
        done_d    = M_Done;
        err_d     = M_Err;
        rdata_d   = M_RData;
        s_addr_d  = S_Addr;
        s_data_d  = S_DataIn;
        s_ctl_d   = S_Control;
        s_en_d    = S_En;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    gnt_d          = '0;
                    gnt_d[sel_idx] = 1'b1;
                    gnt_idx_d      = sel_idx;
                    s_addr_d       = M_Addr[int'(sel_idx)*AW +: AW];
                    s_data_d       = M_DataIn[int'(sel_idx)*DW +: DW];
                    s_ctl_d        = M_Control[int'(sel_idx)*CW +: CW];
                    s_en_d         = 1'b1;
                    cnt_d          = '0;
                    state_d        = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Ready is checked first so it wins over a same-edge timeout.
                if (S_Ready) begin
                    rdata_d           = S_DataOut;
                    done_d[gnt_idx_q] = 1'b1;
                    err_d             = 1'b0;
                    s_en_d            = 1'b0;
                    state_d           = ST_DONE;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    done_d[gnt_idx_q] = 1'b1;
                    err_d             = 1'b1;
                    s_en_d            = 1'b0;
                    state_d           = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = '0;
                err_d   = 1'b0;
                gnt_d   = '0;
                ptr_d   = (gnt_idx_q == PW'(NUM_M - 1)) ? '0 : gnt_idx_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (Rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            cnt_q     <= '0;
            M_Gnt     <= '0;
            M_Done    <= '0;
            M_Err     <= 1'b0;
            M_RData   <= '0;
            S_Addr    <= '0;
            S_DataIn  <= '0;
            S_Control <= '0;
            S_En      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            cnt_q     <= cnt_d;
            M_Gnt     <= gnt_d;
            M_Done    <= done_d;
            M_Err     <= err_d;
            M_RData   <= rdata_d;
            S_Addr    <= s_addr_d;
            S_DataIn  <= s_data_d;
            S_Control <= s_ctl_d;
            S_En      <= s_en_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with two masters and TIMEOUT=16.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_bus_arbiter;

    localparam int NUM_M   = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int CW      = 9;
    localparam int TIMEOUT = 16;

    logic                Clk = 1'b0;
    logic                Rst;
    logic [NUM_M-1:0]    M_Req;
    logic [NUM_M*AW-1:0] M_Addr;
    logic [NUM_M*DW-1:0] M_DataIn;
    logic [NUM_M*CW-1:0] M_Control;
    logic [NUM_M-1:0]    M_Gnt;
    logic [NUM_M-1:0]    M_Done;
    logic                M_Err;
    logic [DW-1:0]       M_RData;
    logic [AW-1:0]       S_Addr;
    logic [DW-1:0]       S_DataIn;
    logic [CW-1:0]       S_Control;
    logic                S_En;
    logic [DW-1:0]       S_DataOut;
    logic                S_Ready;

    int n_cmp = 0;
    int n_err = 0;
    int en_cycles;
    int busy_edges;

    mem_bus_arbiter #(
        .NUM_M(NUM_M), .AW(AW), .DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .M_Req(M_Req), .M_Addr(M_Addr), .M_DataIn(M_DataIn), .M_Control(M_Control),
        .M_Gnt(M_Gnt), .M_Done(M_Done), .M_Err(M_Err), .M_RData(M_RData),
        .S_Addr(S_Addr), .S_DataIn(S_DataIn), .S_Control(S_Control), .S_En(S_En),
        .S_DataOut(S_DataOut), .S_Ready(S_Ready)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst     = 1'b1;
        M_Req   = '0;
        S_Ready = 1'b0;
        tick();
        tick();
        Rst = 1'b0;
    endtask

    initial begin
        M_Addr    = '0;
        M_DataIn  = '0;
        M_Control = '0;
        S_DataOut = '0;
        do_reset();

        check("rst_gnt",   M_Gnt,   0);
        check("rst_done",  M_Done,  0);
        check("rst_err",   M_Err,   0);
        check("rst_rdata", M_RData, 0);
        check("rst_saddr", S_Addr,  0);
        check("rst_sen",   S_En,    0);

        // Test 1: M0 write, Ready seen at the third BUSY edge.
        M_Addr[0 +: AW]    = 32'h0000_034e;
        M_Control[0 +: CW] = 9'h003;
        M_DataIn[0 +: DW]  = 32'hB746_2120;
        M_Req = 2'b01;
        tick();
        check("t1_gnt",   M_Gnt,     2'b01);
        check("t1_sen",   S_En,      1);
        check("t1_saddr", S_Addr,    32'h34e);
        check("t1_sctl",  S_Control, 9'h003);
        check("t1_sdata", S_DataIn,  32'hB746_2120);
        en_cycles = 1;
        tick(); en_cycles += int'(S_En);
        tick(); en_cycles += int'(S_En);
        S_Ready   = 1'b1;
        S_DataOut = 32'h0000_1111;
        tick();
        check("t1_done",  M_Done, 2'b01);
        check("t1_err",   M_Err,  0);
        check("t1_sen_off", S_En, 0);
        check("t1_en_cycles", en_cycles, 3);
        S_Ready = 1'b0;
        M_Req   = 2'b00;
        tick();
        check("t1_done_pulse", M_Done, 0);
        check("t1_gnt_clear",  M_Gnt,  0);

        // Ready while idle must be ignored.
        S_Ready = 1'b1;
        tick();
        check("idle_ready_done", M_Done, 0);
        check("idle_ready_sen",  S_En,   0);
        S_Ready = 1'b0;

        // Test 2: simultaneous requests from reset, then pointer rotation.
        do_reset();
        M_Addr[AW +: AW] = 32'h0000_0200;
        M_Req = 2'b11;
        tick();
        check("t2_first_gnt", M_Gnt, 2'b01);
        S_Ready = 1'b1;
        tick();
        check("t2_first_done", M_Done, 2'b01);
        S_Ready = 1'b0;
        M_Req   = 2'b10;
        tick();
        check("t2_turnaround_sen", S_En, 0);
        tick();
        check("t2_second_gnt", M_Gnt,  2'b10);
        check("t2_second_addr", S_Addr, 32'h200);
        S_Ready = 1'b1;
        tick();
        check("t2_second_done", M_Done, 2'b10);
        S_Ready = 1'b0;
        M_Req   = 2'b00;
        tick();
        M_Req = 2'b11;
        tick();
        check("t2_pair2_gnt", M_Gnt, 2'b01);
        S_Ready = 1'b1;
        tick();
        S_Ready = 1'b0;
        M_Req   = 2'b10;
        tick();
        tick();
        check("t2_pair2_next", M_Gnt, 2'b10);
        S_Ready = 1'b1;
        tick();
        S_Ready = 1'b0;
        M_Req   = 2'b00;
        tick();

        // Test 3: read with data capture, held after completion.
        M_Addr[0 +: AW] = 32'h0000_0078;
        M_Req = 2'b01;
        tick();
        check("t3_saddr", S_Addr, 32'h78);
        S_DataOut = 32'hDEAD_BEEF;
        S_Ready   = 1'b1;
        tick();
        check("t3_done",  M_Done,  2'b01);
        check("t3_rdata", M_RData, 32'hDEAD_BEEF);
        S_Ready   = 1'b0;
        S_DataOut = '0;
        M_Req     = 2'b00;
        tick();
        check("t3_rdata_held", M_RData, 32'hDEAD_BEEF);

        // Test 4: no Ready -> timeout after exactly TIMEOUT BUSY edges.
        M_Req = 2'b10;
        tick();
        check("t4_gnt", M_Gnt, 2'b10);
        busy_edges = 0;
        while (M_Done == 0 && busy_edges < 3 * TIMEOUT) begin
            tick();
            busy_edges++;
        end
        check("t4_busy_edges", busy_edges, TIMEOUT);
        check("t4_done",  M_Done,  2'b10);
        check("t4_err",   M_Err,   1);
        check("t4_rdata", M_RData, 32'hDEAD_BEEF);
        check("t4_sen",   S_En,    0);
        M_Req = 2'b00;
        tick();
        check("t4_err_pulse", M_Err, 0);
        M_Req = 2'b01;
        tick();
        check("t4_recover_gnt", M_Gnt, 2'b01);
        S_DataOut = 32'h1234_5678;
        S_Ready   = 1'b1;
        tick();
        check("t4_recover_err",   M_Err,   0);
        check("t4_recover_rdata", M_RData, 32'h1234_5678);
        S_Ready = 1'b0;
        M_Req   = 2'b00;
        tick();

        // Test 5: reset mid-BUSY drops the transfer and clears the pointer.
        M_Req = 2'b01;
        tick();
        tick();
        check("t5_busy_sen", S_En, 1);
        Rst = 1'b1;
        tick();
        check("t5_sen",  S_En,   0);
        check("t5_gnt",  M_Gnt,  0);
        check("t5_done", M_Done, 0);
        Rst   = 1'b0;
        M_Req = 2'b11;
        tick();
        check("t5_ptr0_gnt", M_Gnt, 2'b01);
        S_Ready = 1'b1;
        tick();
        S_Ready = 1'b0;
        M_Req   = 2'b00;
        tick();

        // Test 6: Ready on the timeout edge wins; address changes ignored in BUSY.
        M_Addr[0 +: AW] = 32'h0000_0ABC;
        M_Req = 2'b01;
        tick();
        check("t6_saddr", S_Addr, 32'hABC);
        M_Addr[AW +: AW] = 32'h0000_0F00;
        M_Addr[0 +: AW]  = 32'h0000_0555;
        M_Req = 2'b10;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("t6_saddr_held", S_Addr, 32'hABC);
        check("t6_gnt_held",   M_Gnt,  2'b01);
        check("t6_no_early_done", M_Done, 0);
        S_DataOut = 32'hCAFE_F00D;
        S_Ready   = 1'b1;
        tick();
        check("t6_done",  M_Done,  2'b01);
        check("t6_err",   M_Err,   0);
        check("t6_rdata", M_RData, 32'hCAFE_F00D);
        S_Ready = 1'b0;
        tick();
        tick();
        check("t6_next_gnt",  M_Gnt,  2'b10);
        check("t6_next_addr", S_Addr, 32'hF00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
